// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes while idle.
// Latency: WIDTH+1 cycles start-to-done (MDU_EARLY_TERM_EN lets multiplies finish early).
// Backpressure: busy holds off the core; start is ignored while busy, with no queuing.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             sa, sb;
    logic [W2-1:0]    acc;     // mul: product; div: {remainder, dividend/quotient}
    logic [W2-1:0]    aux;     // mul: multiplicand shifting left
    logic [WIDTH-1:0] opb;     // mul: multiplier shifting right; div: divisor

    logic             is_div, is_signed, early;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [W2-1:0]    mul_nxt, div_nxt, prod;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;
    logic             div0;

    assign busy      = (state != S_IDLE);
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    assign mul_nxt = opb[0] ? (acc + aux) : acc;

    // Restoring step: a borrow out of the (WIDTH+1)-bit subtract means "restore".
    assign diff    = acc[W2-1:WIDTH-1] - {1'b0, opb};
    assign div_nxt = diff[WIDTH] ? {acc[W2-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MDU_EARLY_TERM_EN
    assign early = ~is_div & (opb[WIDTH-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    assign prod   = (is_signed & (sa ^ sb)) ? -acc : acc;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[W2-1:WIDTH];
    assign div0   = (opb == '0);
    // Divide by zero leaves rem = |a|; re-applying a's sign restores hi = a.
    assign fix_lo = div0 ? '1 : ((is_signed & (sa ^ sb)) ? -quo : quo);
    assign fix_hi = (is_signed & sa) ? -rem : rem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            acc   <= '0;
            aux   <= '0;
            opb   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        op_q  <= op;
                        sa    <= a_neg;
                        sb    <= b_neg;
                        cnt   <= '0;
                        opb   <= b_abs;
                        if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, a_abs};
                            aux <= '0;
                        end else begin
                            acc <= '0;
                            aux <= {{WIDTH{1'b0}}, a_abs};
                        end
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc <= div_nxt;
                    end else begin
                        acc <= mul_nxt;
                        aux <= aux << 1;
                        opb <= opb >> 1;
                    end
                    if (cnt == LAST || early) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= is_div ? fix_hi : prod[W2-1:WIDTH];
                    lo    <= is_div ? fix_lo : prod[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
